// File: rtl/rf_port_sequencer.sv
// Fill/dump sequencer driving one regfile write port and one read port.
// Fill writes base, base+step, ... over an address range; dump streams a range
// out through a 1-entry valid/ready output register.
module rf_port_sequencer #(
  parameter int unsigned ALEN = 5,
  parameter int unsigned DLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_dump,
  input  logic [ALEN-1:0] i_cmd_first,
  input  logic [ALEN-1:0] i_cmd_last,
  input  logic [DLEN-1:0] i_cmd_base,
  input  logic [DLEN-1:0] i_cmd_step,
  output logic            o_rf_wen,
  output logic [ALEN-1:0] o_rf_waddr,
  output logic [DLEN-1:0] o_rf_wdata,
  output logic [ALEN-1:0] o_rf_raddr,
  input  logic [DLEN-1:0] i_rf_rdata,
  output logic            o_dump_valid,
  input  logic            i_dump_ready,
  output logic [ALEN-1:0] o_dump_addr,
  output logic [DLEN-1:0] o_dump_data,
  output logic            o_busy,
  output logic            o_done
);

  typedef enum logic [1:0] {StIdle, StFill, StDump} state_e;

  localparam logic [ALEN-1:0] AddrOne = 1;
  localparam logic [ALEN:0]   CntOne  = 1;

  state_e          state_q;
  logic [ALEN-1:0] ptr_q;   // write pointer in fill, read pointer in dump
  logic [DLEN-1:0] acc_q;
  logic [DLEN-1:0] step_q;
  logic [ALEN:0]   rem_q;   // fill: writes left after the one on the port; dump: reads left

  logic [ALEN-1:0] span;
  logic            dump_take;
  logic            dump_load;

  // Range span wraps mod 2**ALEN, so last < first runs through the top of the file.
  assign span        = i_cmd_last - i_cmd_first;
  assign dump_take   = o_dump_valid & i_dump_ready;
  assign dump_load   = (~o_dump_valid | dump_take) & (rem_q != '0);
  assign o_cmd_ready = (state_q == StIdle);
  assign o_rf_raddr  = ptr_q;

  // Command FSM with all port outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      acc_q        <= '0;
      step_q       <= '0;
      rem_q        <= '0;
      o_rf_wen     <= 1'b0;
      o_rf_waddr   <= '0;
      o_rf_wdata   <= '0;
      o_dump_valid <= 1'b0;
      o_dump_addr  <= '0;
      o_dump_data  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_cmd_valid) begin
            step_q <= i_cmd_step;
            o_busy <= 1'b1;
            if (i_cmd_dump) begin
              state_q <= StDump;
              ptr_q   <= i_cmd_first;
              rem_q   <= {1'b0, span} + CntOne;
            end else begin
              // First write goes straight onto the port in the cycle after accept.
              state_q    <= StFill;
              o_rf_wen   <= 1'b1;
              o_rf_waddr <= i_cmd_first;
              o_rf_wdata <= i_cmd_base;
              ptr_q      <= i_cmd_first + AddrOne;
              acc_q      <= i_cmd_base + i_cmd_step;
              rem_q      <= {1'b0, span};
            end
          end
        end
        StFill: begin
          if (rem_q != '0) begin
            o_rf_wen   <= 1'b1;
            o_rf_waddr <= ptr_q;
            o_rf_wdata <= acc_q;
            ptr_q      <= ptr_q + AddrOne;
            acc_q      <= acc_q + step_q;
            rem_q      <= rem_q - CntOne;
          end else begin
            o_rf_wen <= 1'b0;
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StDump: begin
          if (dump_load) begin
            o_dump_valid <= 1'b1;
            o_dump_addr  <= ptr_q;
            o_dump_data  <= i_rf_rdata;
            ptr_q        <= ptr_q + AddrOne;
            rem_q        <= rem_q - CntOne;
          end else if (dump_take) begin
            // Last beat handed off and nothing left to read.
            o_dump_valid <= 1'b0;
            o_done       <= 1'b1;
            o_busy       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_port_sequencer.sv
// Directed bench for rf_port_sequencer with a behavioural 32x32 regfile.
module tb_rf_port_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dump;
  logic [4:0]  cmd_first;
  logic [4:0]  cmd_last;
  logic [31:0] cmd_base;
  logic [31:0] cmd_step;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;

  logic [31:0] rf_mem  [32];
  logic [31:0] exp_mem [32];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        dump;
    logic [4:0]  first;
    logic [4:0]  last;
    logic [31:0] base;
    logic [31:0] step;
    logic        rand_ready;
    int          count;
  } vec_t;

  vec_t vecs [6];

  rf_port_sequencer #(
    .ALEN(5),
    .DLEN(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_dump   (cmd_dump),
    .i_cmd_first  (cmd_first),
    .i_cmd_last   (cmd_last),
    .i_cmd_base   (cmd_base),
    .i_cmd_step   (cmd_step),
    .o_rf_wen     (rf_wen),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_rf_raddr   (rf_raddr),
    .i_rf_rdata   (rf_rdata),
    .o_dump_valid (dump_valid),
    .i_dump_ready (dump_ready),
    .o_dump_addr  (dump_addr),
    .o_dump_data  (dump_data),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  // Behavioural regfile: synchronous write, combinational read.
  always @(posedge clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_raddr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    logic [4:0]  a;
    logic [31:0] d;
    int          beats;
    int          cyc;
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_dump  = v.dump;
    cmd_first = v.first;
    cmd_last  = v.last;
    cmd_base  = v.base;
    cmd_step  = v.step;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", 64'({busy, cmd_ready}), 64'(2'b10));
    a = v.first;
    if (!v.dump) begin
      d = v.base;
      for (int k = 0; k < v.count; k++) begin
        check("fill_write", 64'({rf_wen, rf_waddr, rf_wdata, done}), 64'({1'b1, a, d, 1'b0}));
        exp_mem[a] = d;
        a = a + 5'd1;
        d = d + v.step;
        @(negedge clk);
      end
      check("fill_end", 64'({rf_wen, done, busy, cmd_ready}), 64'(4'b0101));
    end else begin
      beats = 0;
      cyc   = 0;
      while (beats < v.count && cyc < 400) begin
        check("dump_no_write", 64'(rf_wen), 64'(0));
        if (dump_valid)
          check("dump_beat", 64'({dump_addr, dump_data, done}), 64'({a, exp_mem[a], 1'b0}));
        dump_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dump_valid && dump_ready) begin
          beats++;
          a = a + 5'd1;
        end
        @(negedge clk);
        cyc++;
      end
      check("dump_beats", 64'(beats), 64'(v.count));
      if (!v.rand_ready) check("dump_rate", 64'(cyc), 64'(v.count + 1));
      check("dump_end", 64'({dump_valid, done, busy, cmd_ready, rf_wen}), 64'(5'b01010));
      dump_ready = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    vec_t tail;
    vecs[0] = '{1'b0, 5'd0,  5'd31, 32'hffffff20, 32'hffffffff, 1'b0, 32};
    vecs[1] = '{1'b1, 5'd0,  5'd31, 32'h0,        32'h0,        1'b0, 32};
    vecs[2] = '{1'b1, 5'd28, 5'd3,  32'h0,        32'h0,        1'b1, 8};
    vecs[3] = '{1'b0, 5'd30, 5'd1,  32'd7,        32'd1,        1'b0, 4};
    vecs[4] = '{1'b0, 5'd5,  5'd5,  32'hdeadbeef, 32'h11,       1'b0, 1};
    vecs[5] = '{1'b1, 5'd29, 5'd6,  32'h0,        32'h0,        1'b1, 10};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dump   = 1'b0;
    cmd_first  = '0;
    cmd_last   = '0;
    cmd_base   = '0;
    cmd_step   = '0;
    dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({cmd_ready, rf_wen, dump_valid, busy, done, rf_raddr, dump_addr}),
          64'({1'b1, 4'b0000, 5'd0, 5'd0}));
    check("reset_data", 64'({rf_waddr, rf_wdata}), 64'(0));
    check("reset_dump_data", 64'(dump_data), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i]);
      if (i == 0)
        for (int r = 0; r < 32; r++)
          check("fill_pattern", 64'(rf_mem[r]), 64'(32'hffffff00 | 32'(32 - r)));
    end

    // Reset during write #10 of a fill aborts without o_done.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dump = 1'b0; cmd_first = 5'd0; cmd_last = 5'd31;
    cmd_base  = 32'h100; cmd_step = 32'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_write10", 64'({rf_wen, rf_waddr, rf_wdata}), 64'({1'b1, 5'd9, 32'h109}));
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", 64'({rf_wen, done, cmd_ready, busy}), 64'(4'b0010));
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("abort_quiet", 64'({rf_wen, done}), 64'(0));
      @(negedge clk);
    end
    for (int r = 0; r < 10; r++) begin
      check("abort_regs", 64'(rf_mem[r]), 64'(32'h100 + 32'(r)));
      exp_mem[r] = 32'h100 + 32'(r);
    end
    check("abort_reg10", 64'(rf_mem[10]), 64'(exp_mem[10]));

    // Valid held while busy: the second command waits for the first to finish.
    cmd_valid = 1'b1; cmd_first = 5'd0; cmd_last = 5'd3;
    cmd_base  = 32'ha0; cmd_step = 32'h10;
    @(negedge clk);
    cmd_first = 5'd8; cmd_last = 5'd9; cmd_base = 32'h55; cmd_step = 32'h0;
    for (int k = 0; k < 4; k++) begin
      check("hold_write", 64'({cmd_ready, rf_wen, rf_waddr, rf_wdata}),
            64'({1'b0, 1'b1, 5'(k), 32'ha0 + 32'(k) * 32'h10}));
      exp_mem[k] = 32'ha0 + 32'(k) * 32'h10;
      @(negedge clk);
    end
    check("hold_done", 64'({done, cmd_ready, rf_wen}), 64'(3'b110));
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold_second_0", 64'({rf_wen, rf_waddr, rf_wdata, done}),
          64'({1'b1, 5'd8, 32'h55, 1'b0}));
    @(negedge clk);
    check("hold_second_1", 64'({rf_wen, rf_waddr, rf_wdata, done}),
          64'({1'b1, 5'd9, 32'h55, 1'b0}));
    @(negedge clk);
    check("hold_second_done", 64'({rf_wen, done}), 64'(2'b01));
    exp_mem[8] = 32'h55;
    exp_mem[9] = 32'h55;

    tail = '{1'b1, 5'd0, 5'd11, 32'h0, 32'h0, 1'b1, 12};
    run_cmd(tail);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
